// File: rtl/conv_frame_writer_pkg.sv
// Shared types, frame geometry and pixel conversion for conv_frame_writer.
// Optional CONV_FRAME_WRITER_SAT_EN: conv8 clips magnitudes above 255 instead of wrapping.
package conv_frame_writer_pkg;

    localparam int IMG_W        = 220;
    localparam int IMG_H        = 220;
    localparam int KSIZE        = 5;
    localparam int OW           = IMG_W - KSIZE + 1;
    localparam int OH           = IMG_H - KSIZE + 1;
    localparam int FRAME_PIXELS = OW * OH;

    localparam int PIX_IN_W  = 16;
    localparam int PIX_OUT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // Magnitude of a two's-complement result reduced to 8 bits; -32768 has magnitude 0x8000.
    function automatic logic [PIX_OUT_W-1:0] conv8(input logic [PIX_IN_W-1:0] pix);
        logic [PIX_IN_W-1:0] mag;
        mag = pix[PIX_IN_W-1] ? (~pix) + PIX_IN_W'(1) : pix;
`ifdef CONV_FRAME_WRITER_SAT_EN
        conv8 = (mag > PIX_IN_W'(255)) ? '1 : PIX_OUT_W'(mag);
`else
        conv8 = PIX_OUT_W'(mag);
`endif
    endfunction

endpackage

// File: rtl/conv_frame_writer_frame_ram.sv
// Frame buffer: one write port, one registered read port (1-cycle latency, holds when not read).
module frame_ram #(
    parameter int AW = 16,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [0:(1<<AW)-1];
    logic [DW-1:0] r_rdata;

    // NOTE: the array and its read register have no reset so they map onto block RAM;
    // a reset here would force a flop array and the contents are never assumed anyway.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/conv_frame_writer.sv
// Captures one convolution output frame into frame_ram, then drains it over valid/ready.
// Optional CONV_FRAME_WRITER_SAT_EN selects saturating 16->8 bit conversion.
module conv_frame_writer
    import conv_frame_writer_pkg::*;
#(
    parameter int W  = IMG_W,
    parameter int H  = IMG_H,
    parameter int K  = KSIZE,
    parameter int AW = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [PIX_IN_W-1:0]  pxl_in,
    input  logic                 pxl_valid,
    output logic [PIX_OUT_W-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic                 busy,
    output logic                 done,
    output logic                 overrun
);

    localparam int            FRM_PIXELS = (W - K + 1) * (H - K + 1);
    localparam logic [AW-1:0] LAST_ADDR  = AW'(FRM_PIXELS - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [AW-1:0]         r_wr_addr;
    logic [AW-1:0]         r_rd_addr;
    logic                  r_rd_issued_all;
    logic                  r_ram_vld;
    logic                  r_ram_last;
    logic                  r_out_valid;
    logic                  r_out_last;
    logic [PIX_OUT_W-1:0]  r_out_data;
    logic                  r_overrun;

    logic                  w_we;
    logic                  w_re;
    logic                  w_out_take;
    logic                  w_cap_last;
    logic                  w_busy;
    logic                  w_done;
    logic [PIX_OUT_W-1:0]  w_ram_rdata;

    // NOTE: every flop uses non-blocking assignment so all state updates see pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: all outputs of this block get a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_we        = 1'b0;
        w_re        = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        w_cap_last  = 1'b0;
        w_out_take  = !r_out_valid || out_ready;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                w_busy     = 1'b1;
                w_we       = pxl_valid;
                w_cap_last = pxl_valid && (r_wr_addr == LAST_ADDR);
                if (w_cap_last) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                w_busy = 1'b1;
                // Read ahead whenever the RAM output register is empty or is moving on.
                w_re   = !r_rd_issued_all && (!r_ram_vld || w_out_take);
                if (r_out_valid && out_ready && r_out_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_addr       <= '0;
            r_rd_addr       <= '0;
            r_rd_issued_all <= 1'b0;
            r_overrun       <= 1'b0;
        end else begin
            // A stray pixel outranks the clear so start+pxl_valid in IDLE leaves the flag set.
            if (pxl_valid && r_state != ST_CAPTURE) begin
                r_overrun <= 1'b1;
            end else if (start && r_state == ST_IDLE) begin
                r_overrun <= 1'b0;
            end

            if (start && r_state == ST_IDLE) begin
                r_wr_addr <= '0;
            end else if (w_we) begin
                r_wr_addr <= r_wr_addr + AW'(1);
            end

            if (w_cap_last) begin
                r_rd_addr       <= '0;
                r_rd_issued_all <= 1'b0;
            end else if (w_re) begin
                r_rd_addr <= r_rd_addr + AW'(1);
                if (r_rd_addr == LAST_ADDR) begin
                    r_rd_issued_all <= 1'b1;
                end
            end
        end
    end

    // Two-stage drain pipe: RAM read register, then the output register facing the consumer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ram_vld   <= 1'b0;
            r_ram_last  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
        end else if (r_state != ST_DRAIN) begin
            r_ram_vld   <= 1'b0;
            r_ram_last  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            if (w_re) begin
                r_ram_vld  <= 1'b1;
                r_ram_last <= (r_rd_addr == LAST_ADDR);
            end else if (w_out_take) begin
                r_ram_vld <= 1'b0;
            end

            if (w_out_take) begin
                r_out_valid <= r_ram_vld;
                r_out_last  <= r_ram_vld && r_ram_last;
                if (r_ram_vld) begin
                    r_out_data <= w_ram_rdata;
                end
            end
        end
    end

    frame_ram #(
        .AW (AW),
        .DW (PIX_OUT_W)
    ) u_frame_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_wr_addr),
        .i_wdata (conv8(pxl_in)),
        .i_re    (w_re),
        .i_raddr (r_rd_addr),
        .o_rdata (w_ram_rdata)
    );

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign busy      = w_busy;
    assign done      = w_done;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_conv_frame_writer.sv
// Directed bench for conv_frame_writer on a reduced 24x24 image (20x20 = 400-pixel frame).
module tb_conv_frame_writer;

    localparam int W    = 24;
    localparam int H    = 24;
    localparam int K    = 5;
    localparam int AW   = 9;
    localparam int NPIX = (W - K + 1) * (H - K + 1);

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] pxl_in;
    logic        pxl_valid;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;
    logic        done;
    logic        overrun;

    int vectors     = 0;
    int miscompares = 0;

    logic [15:0] src_pix [NPIX];
    logic [7:0]  exp_pix [NPIX];

    always #5 clk = ~clk;

    conv_frame_writer #(
        .W  (W),
        .H  (H),
        .K  (K),
        .AW (AW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .pxl_in    (pxl_in),
        .pxl_valid (pxl_valid),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .overrun   (overrun)
    );

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    // Outputs are observed and inputs changed 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_counting();
        for (int i = 0; i < NPIX; i++) begin
            src_pix[i] = 16'(i % 256);
            exp_pix[i] = 8'(i % 256);
        end
    endtask

    task automatic capture_frame(input bit gaps);
        for (int i = 0; i < NPIX; i++) begin
            if (gaps) begin
                pxl_valid = 1'b0;
                pxl_in    = 16'hBEEF;
                tick();
                tick();
            end
            pxl_valid = 1'b1;
            pxl_in    = src_pix[i];
            tick();
        end
        pxl_valid = 1'b0;
        vectors++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL drain_entry: busy=%b out_valid=%b, expected busy=1 out_valid=0", busy, out_valid);
        end
    endtask

    // Called on the first DRAIN cycle; checks data order, out_last, stalls, timing and done.
    task automatic drain_frame(input bit rand_ready, input bit poke_pixel, input bit start_in_done);
        int         n         = 0;
        int         cyc       = 0;
        int         first     = -1;
        int         last_cyc  = -1;
        int         done_cyc  = -1;
        int         done_cnt  = 0;
        bit         held_v    = 1'b0;
        logic [7:0] held_d    = '0;
        logic       held_l    = 1'b0;
        bit         finished  = 1'b0;
        while (!finished && cyc < 8 * NPIX + 50) begin
            if (held_v) begin
                vectors++;
                if (out_valid !== 1'b1 || out_data !== held_d || out_last !== held_l) begin
                    miscompares++;
                    $display("FAIL stall_hold cyc %0d: valid=%b data=%h last=%b, required 1 %h %b",
                             cyc, out_valid, out_data, out_last, held_d, held_l);
                end
            end
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            start     = start_in_done && (done === 1'b1);
            if (poke_pixel && cyc == 5) begin
                pxl_valid = 1'b1;
                pxl_in    = 16'h00AA;
            end else begin
                pxl_valid = 1'b0;
            end
            if (out_valid === 1'b1 && first < 0) first = cyc;
            if (out_valid === 1'b1 && out_ready && n < NPIX) begin
                vectors++;
                if (out_data !== exp_pix[n] || out_last !== (n == NPIX - 1)) begin
                    miscompares++;
                    $display("FAIL drain_word %0d: data=%h last=%b, required %h %b",
                             n, out_data, out_last, exp_pix[n], (n == NPIX - 1));
                end
                n++;
                if (n == NPIX) last_cyc = cyc;
            end
            held_v = (out_valid === 1'b1) && !out_ready;
            held_d = out_data;
            held_l = out_last;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            tick();
            cyc++;
            if (last_cyc >= 0 && cyc > last_cyc + 3) finished = 1'b1;
        end
        start     = 1'b0;
        pxl_valid = 1'b0;
        vectors++;
        if (n != NPIX) begin
            miscompares++;
            $display("FAIL drain_count: %0d words transferred, required %0d", n, NPIX);
        end
        vectors++;
        if (first != 2) begin
            miscompares++;
            $display("FAIL first_valid: out_valid rose %0d cycles after DRAIN entry, required 2", first);
        end
        vectors++;
        if (done_cnt != 1 || done_cyc != last_cyc + 1) begin
            miscompares++;
            $display("FAIL done_pulse: %0d pulses at cycle %0d, required 1 at cycle %0d",
                     done_cnt, done_cyc, last_cyc + 1);
        end
        if (!rand_ready) begin
            vectors++;
            if (last_cyc - first != NPIX - 1) begin
                miscompares++;
                $display("FAIL throughput: %0d cycles first to last, required %0d",
                         last_cyc - first, NPIX - 1);
            end
        end
        vectors++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0) begin
            miscompares++;
            $display("FAIL post_drain: busy=%b out_valid=%b out_last=%b, required 0 0 0",
                     busy, out_valid, out_last);
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        start     = 1'b0;
        pxl_valid = 1'b0;
        pxl_in    = '0;
        out_ready = 1'b0;
        repeat (2) tick();
        vectors++;
        if ({out_data, out_valid, out_last, busy, done, overrun} !== 13'h0) begin
            miscompares++;
            $display("FAIL reset_state: outputs %h, required 0",
                     {out_data, out_valid, out_last, busy, done, overrun});
        end
        reset = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL start_capture: busy=%b, required 1", busy);
        end
        pxl_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            pxl_in = 16'(i + 7);
            tick();
        end
        vectors++;
        if (busy !== 1'b1 || overrun !== 1'b0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_capture: busy=%b overrun=%b out_valid=%b, required 1 0 0",
                     busy, overrun, out_valid);
        end
        #2 reset = 1'b1;
        #1;
        vectors++;
        if ({out_data, out_valid, out_last, busy, done, overrun} !== 13'h0) begin
            miscompares++;
            $display("FAIL async_reset: outputs %h, required 0",
                     {out_data, out_valid, out_last, busy, done, overrun});
        end
        pxl_valid = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        vectors++;
        if (busy !== 1'b0 || overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL after_reset: busy=%b overrun=%b, required 0 0", busy, overrun);
        end
    endtask

    // Follows the abandoned partial frame: a fresh start must refill from address 0.
    task automatic test_full_frame();
        fill_counting();
        start = 1'b1;
        tick();
        start = 1'b0;
        vectors++;
        if (busy !== 1'b1 || overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL full_start: busy=%b overrun=%b, required 1 0", busy, overrun);
        end
        capture_frame(1'b0);
        drain_frame(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_gaps_backpressure();
        fill_counting();
        start = 1'b1;
        tick();
        start = 1'b0;
        capture_frame(1'b1);
        drain_frame(1'b1, 1'b0, 1'b0);
        vectors++;
        if (overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL gaps_overrun: overrun=%b, required 0", overrun);
        end
    endtask

    task automatic test_overrun();
        for (int i = 0; i < NPIX; i++) begin
            src_pix[i] = 16'(255 - (i % 256));
            exp_pix[i] = 8'(255 - (i % 256));
        end
        pxl_valid = 1'b1;
        pxl_in    = 16'h0055;
        tick();
        pxl_valid = 1'b0;
        vectors++;
        if (overrun !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_overrun: overrun=%b busy=%b, required 1 0", overrun, busy);
        end
        tick();
        vectors++;
        if (overrun !== 1'b1) begin
            miscompares++;
            $display("FAIL overrun_sticky: overrun=%b, required 1", overrun);
        end
        start     = 1'b1;
        pxl_valid = 1'b1;
        pxl_in    = 16'h0077;
        tick();
        start     = 1'b0;
        pxl_valid = 1'b0;
        vectors++;
        if (busy !== 1'b1 || overrun !== 1'b1) begin
            miscompares++;
            $display("FAIL start_with_pixel: busy=%b overrun=%b, required 1 1", busy, overrun);
        end
        capture_frame(1'b0);
        drain_frame(1'b0, 1'b1, 1'b0);
        vectors++;
        if (overrun !== 1'b1) begin
            miscompares++;
            $display("FAIL drain_overrun: overrun=%b, required 1", overrun);
        end
    endtask

    // Starts with overrun still set from the previous scenario; this start must clear it.
    task automatic test_conv8();
        fill_counting();
        src_pix[0] = 16'hFFF6;
        exp_pix[0] = 8'h0A;
        src_pix[1] = 16'h012C;
`ifdef CONV_FRAME_WRITER_SAT_EN
        exp_pix[1] = 8'hFF;
`else
        exp_pix[1] = 8'h2C;
`endif
        src_pix[2] = 16'h8000;
`ifdef CONV_FRAME_WRITER_SAT_EN
        exp_pix[2] = 8'hFF;
`else
        exp_pix[2] = 8'h00;
`endif
        src_pix[3] = 16'hFF01;
        exp_pix[3] = 8'hFF;
        src_pix[4] = 16'h0080;
        exp_pix[4] = 8'h80;
        start = 1'b1;
        tick();
        start = 1'b0;
        vectors++;
        if (overrun !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL overrun_clear: overrun=%b busy=%b, required 0 1", overrun, busy);
        end
        capture_frame(1'b0);
        drain_frame(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_gaps_backpressure();
        test_overrun();
        test_conv8();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/conv_frame_writer.md
Name: conv_frame_writer

Overview:
- Sink-side counterpart of the 5x5 streaming convolution: consumes its pxl_out/valid stream and stores one output frame.
- Converts each valid 16-bit result to an 8-bit pixel and writes it into an internal frame buffer of OW*OH entries in raster order.
- Once the frame is complete, drains it to the downstream consumer over a valid/ready stream, then signals done.
- Sits between the convolution core and the display/readout path.

Parameters:
- W, 220, input image width.
- H, 220, input image height.
- K, 5, kernel size; output frame is OW = W-K+1 by OH = H-K+1 (216x216 = 46656 pixels).
- AW, 16, address width; must satisfy 2^AW >= OW*OH.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; arms capture of one frame.
- pxl_in  input  16  convolution result, two's complement.
- pxl_valid  input  1  pxl_in carries a valid window result this cycle.
- out_data  output  8  drained pixel.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts out_data.
- out_last  output  1  marks the final pixel of the frame, valid with out_valid.
- busy  output  1  high in CAPTURE or DRAIN.
- done  output  1  one-cycle pulse after the last pixel is accepted.
- overrun  output  1  sticky flag: pxl_valid seen while not in CAPTURE.

Behaviour:
- Clocking and reset: one clock, clk. reset is asynchronous and active-high.
  - On reset: state = IDLE; wr_addr = rd_addr = 0; out_valid = out_last = done = busy = overrun = 0; out_data = 0.
  - Memory contents are not cleared.
- States: IDLE -> CAPTURE -> DRAIN -> DONE -> IDLE.
- IDLE:
  - start=1 moves to CAPTURE next cycle and clears wr_addr and overrun.
  - pxl_valid=1 sets overrun and writes nothing.
- CAPTURE:
  - Each cycle with pxl_valid=1 writes conv8(pxl_in) to mem[wr_addr], then wr_addr increments.
  - A write at wr_addr = OW*OH-1 moves to DRAIN, with rd_addr = 0.
  - start is ignored.
- conv8 without the feature: absolute value of the signed 16-bit input, then take the low 8 bits. -32768 maps to 0x00.
- DRAIN:
  - Memory read is synchronous with 1-cycle latency. The first out_valid rises 2 cycles after DRAIN is entered (1 prefetch cycle plus the read latency).
  - A transfer occurs when out_valid && out_ready.
  - While out_valid && !out_ready, out_data and out_last are held stable.
  - The next word is prefetched, so back-to-back transfers sustain 1 pixel per cycle.
  - out_last = 1 with the word at rd_addr = OW*OH-1.
  - pxl_valid in DRAIN sets overrun; no write occurs.
- DONE:
  - Entered on the transfer of the last word.
  - out_valid = 0 and done = 1 for exactly one cycle, then IDLE.
- Simultaneous events:
  - start together with pxl_valid in IDLE: the pixel is not written and overrun is set; capture starts next cycle.
  - start in DONE is ignored.
- Reset mid-operation: immediate return to IDLE; a partial frame is abandoned.
- busy = (state == CAPTURE || state == DRAIN).

Optional Feature:
- Macro: CONV_FRAME_WRITER_SAT_EN.
- Defined: conv8 clips the absolute value at 255. Example: abs = 300 gives 0xFF.
- Not defined: conv8 takes abs[7:0]. Example: abs = 300 gives 0x2C.

Decomposition:
- Shared package holds:
  - state encoding (IDLE=0, CAPTURE=1, DRAIN=2, DONE=3);
  - derived constants OW, OH, FRAME_PIXELS = OW*OH;
  - the pixel width constants (16-bit in, 8-bit out).
- One sub-module: frame_ram, a single-port-write / single-port-read synchronous RAM, depth 2^AW, 8 bits wide, 1-cycle read latency.

Test Plan:
- Reset mid-CAPTURE after 100 writes -> all outputs 0 and state IDLE within the same cycle; a later start re-captures from address 0.
- start, then feed 46656 pixels with pxl_in = index mod 256 and pxl_valid always 1 -> transition to DRAIN; out_data sequence equals 0,1,...,255,0,...; out_last only on word 46655; done pulses exactly once.
- Input with gaps (pxl_valid 1 every 3rd cycle) plus random out_ready in DRAIN -> identical data sequence; out_data stable whenever out_valid && !out_ready.
- pxl_in = 0xFFF6 (-10), 0x012C (300), 0x8000 -> stored values 10, 0x2C (0xFF with CONV_FRAME_WRITER_SAT_EN), 0x00.
- pxl_valid=1 in IDLE, and again during DRAIN -> overrun = 1 and stays set; frame contents unchanged; overrun clears on the next start.
- out_ready held at 1 through the whole drain -> 46656 transfers in 46656 consecutive cycles after the first out_valid.
